// File: rtl/hilo_muldiv_reader_pkg.sv
// Shared types for the HI/LO multiply/divide unit: control bundle, ALU function
// codes, FSM state encoding and the HI/LO function classification.
package hilo_muldiv_reader_pkg;

  typedef struct packed {
    logic clk;
    logic rst;
  } Data_Control_Control_T;

  typedef enum logic [4:0] {
    FUNC_ADD  = 5'd0,
    FUNC_SUB  = 5'd1,
    FUNC_AND  = 5'd2,
    FUNC_OR   = 5'd3,
    FUNC_XOR  = 5'd4,
    FUNC_NOR  = 5'd5,
    FUNC_SLT  = 5'd6,
    FUNC_SLTU = 5'd7,
    FUNC_SLL  = 5'd8,
    FUNC_SRL  = 5'd9,
    FUNC_SRA  = 5'd10,
    FUNC_MULU = 5'd11,
    FUNC_MULS = 5'd12,
    FUNC_DIVU = 5'd13,
    FUNC_DIVS = 5'd14,
    FUNC_MTHI = 5'd15,
    FUNC_MTLO = 5'd16
  } Mips_Control_Type_Signal_Alu_Signal_Func_T;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_SIGN = 2'd3
  } hilo_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  // Ceiling log2; the iteration counter needs one extra bit to hold DATA_W itself.
  function automatic int Util_Math_log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic logic is_hilo_func(input Mips_Control_Type_Signal_Alu_Signal_Func_T func);
    return func inside {FUNC_MULU, FUNC_MULS, FUNC_DIVU, FUNC_DIVS, FUNC_MTHI, FUNC_MTLO};
  endfunction

endpackage

// File: rtl/hilo_muldiv_reader_step.sv
// One combinational iteration: right-shift/add multiply step or restoring divide step.
// The accumulator holds {partial, multiplier} for MUL and {remainder, dividend} for DIV.
module hilo_muldiv_reader_step
  import hilo_muldiv_reader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  step_mode_e              mode_i,
  input  logic [2*DATA_W-1:0]     acc_i,
  input  logic [DATA_W-1:0]       operand_i,
  output logic [2*DATA_W-1:0]     acc_o,
  output logic                    qbit_o
);

  logic [DATA_W:0] mulSum;
  logic [DATA_W:0] divShift;
  logic [DATA_W:0] divTrial;

  // The divide step leaves bit 0 clear; the caller merges in the quotient bit.
  always_comb begin
    mulSum   = {1'b0, acc_i[2*DATA_W-1:DATA_W]} + {1'b0, (acc_i[0] ? operand_i : {DATA_W{1'b0}})};
    divShift = {acc_i[2*DATA_W-1:DATA_W], acc_i[DATA_W-1]};
    divTrial = divShift - {1'b0, operand_i};
    acc_o    = '0;
    qbit_o   = 1'b0;
    if (mode_i == STEP_MUL) begin
      acc_o = {mulSum, acc_i[DATA_W-1:1]};
    end else begin
      qbit_o = (divShift >= {1'b0, operand_i});
      acc_o  = {(qbit_o ? divTrial[DATA_W-1:0] : divShift[DATA_W-1:0]),
                acc_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv_reader.sv
// Iterative HI/LO unit: accepts mult/div/mthi/mtlo, owns HI/LO and serves
// MFHI/MFLO reads, which stall while an operation is in flight.
module hilo_muldiv_reader
  import hilo_muldiv_reader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = Util_Math_log2(DATA_W) + 1
) (
  input  Data_Control_Control_T                     ctrl,
  input  logic                                      req_valid,
  input  Mips_Control_Type_Signal_Alu_Signal_Func_T req_func,
  input  logic [DATA_W-1:0]                         req_data1,
  input  logic [DATA_W-1:0]                         req_data2,
  output logic                                      req_ready,
  input  logic                                      rd_valid,
  input  logic                                      rd_sel,
  output logic                                      rd_ready,
  output logic [DATA_W-1:0]                         rd_data,
  output logic                                      busy,
  output logic                                      dbz
);

  logic clk;
  logic rst;
  assign clk = ctrl.clk;
  assign rst = ctrl.rst;

  hilo_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   operand_q, operand_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic                isDiv_q, isDiv_d;
  logic                dbz_q, dbz_d;

  step_mode_e          stepMode;
  logic [2*DATA_W-1:0] stepAcc;
  logic                stepQbit;
  logic                accept;
  logic                isSigned;
  logic                sign1;
  logic                sign2;

  function automatic logic [DATA_W-1:0] magOf(input logic [DATA_W-1:0] v, input logic s);
    return (s && v[DATA_W-1]) ? -v : v;
  endfunction

  assign accept   = req_valid && (state_q == ST_IDLE);
  assign isSigned = (req_func == FUNC_MULS) || (req_func == FUNC_DIVS);
  assign sign1    = isSigned && req_data1[DATA_W-1];
  assign sign2    = isSigned && req_data2[DATA_W-1];
  assign stepMode = (state_q == ST_DIV) ? STEP_DIV : STEP_MUL;

  hilo_muldiv_reader_step #(.DATA_W(DATA_W)) u_step (
    .mode_i    (stepMode),
    .acc_i     (acc_q),
    .operand_i (operand_q),
    .acc_o     (stepAcc),
    .qbit_o    (stepQbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      isDiv_q   <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      operand_q <= operand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      isDiv_q   <= isDiv_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    operand_d = operand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    isDiv_d   = isDiv_q;
    dbz_d     = dbz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && is_hilo_func(req_func)) begin
          unique case (req_func)
            FUNC_MULU, FUNC_MULS: begin
              operand_d = magOf(req_data1, isSigned);
              acc_d     = {{DATA_W{1'b0}}, magOf(req_data2, isSigned)};
              neg_d     = sign1 ^ sign2;
              isDiv_d   = 1'b0;
              cnt_d     = CNT_W'(DATA_W);
              state_d   = ST_MUL;
            end
            FUNC_DIVU, FUNC_DIVS: begin
              // A zero divisor commits immediately without iterating.
              if (req_data2 == '0) begin
                hi_d  = req_data1;
                lo_d  = '1;
                dbz_d = 1'b1;
              end else begin
                operand_d = magOf(req_data2, isSigned);
                acc_d     = {{DATA_W{1'b0}}, magOf(req_data1, isSigned)};
                neg_d     = sign1 ^ sign2;
                rneg_d    = sign1;
                isDiv_d   = 1'b1;
                cnt_d     = CNT_W'(DATA_W);
                state_d   = ST_DIV;
              end
            end
            FUNC_MTHI: hi_d = req_data1;
            FUNC_MTLO: lo_d = req_data1;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d = stepAcc | {{(2*DATA_W-1){1'b0}}, stepQbit};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        if (isDiv_q) begin
          lo_d  = neg_q  ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
          hi_d  = rneg_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
          dbz_d = 1'b0;
        end else begin
          {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign dbz       = dbz_q;
  assign req_ready = !rst && !busy;
  assign rd_ready  = !rst && !busy;
  assign rd_data   = (rd_ready && rd_valid) ? (rd_sel ? hi_q : lo_q) : '0;

endmodule
